// File: rtl/xillybus_mem8_responder_if.sv
// xillybus_mem8_responder_if
//   Signal bundle for the seekable 8-bit mem_8 stream pair between
//   xillybus_core (master) and the user-side responder (slave).
//   Write side : wren, data (in), full (out), w_open (in)
//   Read side  : rden (in), rd data, empty, eof (out), r_open (in)
//   Seek       : addr, addr_update (in)
interface xillybus_mem8_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              user_w_mem_8_wren;
    logic [DATA_W-1:0] user_w_mem_8_data;
    logic              user_w_mem_8_full;
    logic              user_w_mem_8_open;
    logic              user_r_mem_8_rden;
    logic [DATA_W-1:0] user_r_mem_8_data;
    logic              user_r_mem_8_empty;
    logic              user_r_mem_8_eof;
    logic              user_r_mem_8_open;
    logic [ADDR_W-1:0] user_mem_8_addr;
    logic              user_mem_8_addr_update;

    modport master (
        output user_w_mem_8_wren, user_w_mem_8_data, user_w_mem_8_open,
        output user_r_mem_8_rden, user_r_mem_8_open,
        output user_mem_8_addr, user_mem_8_addr_update,
        input  user_w_mem_8_full, user_r_mem_8_data, user_r_mem_8_empty,
        input  user_r_mem_8_eof
    );

    modport slave (
        input  user_w_mem_8_wren, user_w_mem_8_data, user_w_mem_8_open,
        input  user_r_mem_8_rden, user_r_mem_8_open,
        input  user_mem_8_addr, user_mem_8_addr_update,
        output user_w_mem_8_full, user_r_mem_8_data, user_r_mem_8_empty,
        output user_r_mem_8_eof
    );
endinterface

// File: rtl/xillybus_mem8_responder.sv
// xillybus_mem8_responder
//   DEPTH-byte addressable memory behind the Xillybus mem_8 stream pair.
//   A single pointer is shared by both directions: the host seeks with
//   addr/addr_update, then writes or reads bytes with auto-increment.
//   Ports:
//     bus_clk    - bus clock, the only clock
//     bus_rst_n  - synchronous active-low reset
//     mem8       - stream/seek bundle (slave side)
//   DEPTH must equal 2**ADDR_W so the pointer wraps naturally.
module xillybus_mem8_responder #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 32,
    parameter int EOF_AT_END = 1
) (
    input  logic                        bus_clk,
    input  logic                        bus_rst_n,
    xillybus_mem8_responder_if.slave    mem8
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] ptr;
    logic              done;
    logic              bubble;
    logic              r_open_q;
    logic              full;
    logic              empty;
    logic              eof;
    logic [DATA_W-1:0] rd_data;

    logic wr_acc;
    logic rd_acc;
    logic open_fall;
    logic done_next;
    logic bubble_next;

    always_comb begin
        // A seek swallows any strobe issued in the same cycle.
        wr_acc    = mem8.user_w_mem_8_wren & ~full & ~mem8.user_mem_8_addr_update;
        // bubble always implies empty; checked too so a read can never
        // see a location that is still being updated.
        rd_acc    = mem8.user_r_mem_8_rden & ~empty & ~bubble
                    & ~mem8.user_mem_8_addr_update;
        open_fall = r_open_q & ~mem8.user_r_mem_8_open;

        done_next = done;
        if (mem8.user_mem_8_addr_update || open_fall) begin
            done_next = 1'b0;
        end else if (rd_acc && (EOF_AT_END != 0) && (ptr == LAST_ADDR)) begin
            done_next = 1'b1;
        end

        bubble_next = mem8.user_mem_8_addr_update | wr_acc;
    end

    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            ptr      <= '0;
            done     <= 1'b0;
            bubble   <= 1'b1;
            r_open_q <= 1'b0;
            full     <= 1'b1;
            empty    <= 1'b1;
            eof      <= 1'b0;
            rd_data  <= '0;
        end else begin
            r_open_q <= mem8.user_r_mem_8_open;
            full     <= 1'b0;
            done     <= done_next;
            bubble   <= bubble_next;
            empty    <= ~mem8.user_r_mem_8_open | bubble_next | done_next;
            eof      <= done_next & mem8.user_r_mem_8_open;

            if (rd_acc) begin
                rd_data <= mem[ptr];
            end

            if (mem8.user_mem_8_addr_update) begin
                ptr <= mem8.user_mem_8_addr;
            end else if (wr_acc || rd_acc) begin
                // Simultaneous read and write share one location: +1 only.
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end

    // Memory is deliberately outside reset so contents survive it.
    // Read-first on a same-cycle read/write falls out of the NBA ordering.
    always_ff @(posedge bus_clk) begin
        if (bus_rst_n && wr_acc) begin
            mem[ptr] <= mem8.user_w_mem_8_data;
        end
    end

    assign mem8.user_w_mem_8_full  = full;
    assign mem8.user_r_mem_8_empty = empty;
    assign mem8.user_r_mem_8_eof   = eof;
    assign mem8.user_r_mem_8_data  = rd_data;
endmodule

// File: doc/xillybus_mem8_responder.md
Name: xillybus_mem8_responder

Overview:
- User-side responder for the seekable 8-bit `mem_8` stream pair driven by the Xillybus core: a DEPTH-byte addressable memory with a shared address pointer.
- The host seeks via `user_mem_8_addr`/`user_mem_8_addr_update`, then streams bytes in (write side) or out (read side), with the pointer auto-incrementing.
- The block sits in the `bus_clk` domain beside `xillybus_core` and replaces the ad-hoc demo RAM.

Parameters:
- DATA_W, 8, byte width of both streams.
- ADDR_W, 5, width of `user_mem_8_addr`.
- DEPTH, 32, number of memory locations; must equal 2**ADDR_W.
- EOF_AT_END, 1, when 1 a read of the last location ends the read stream with eof; when 0 reads wrap silently.

Ports:
- bus_clk  in  1  Xillybus bus clock; the only clock.
- bus_rst_n  in  1  reset, synchronous, active-low.
- user_w_mem_8_wren  in  1  write strobe from core.
- user_w_mem_8_data  in  DATA_W  write byte.
- user_w_mem_8_full  out  1  back-pressure to core.
- user_w_mem_8_open  in  1  host write file open.
- user_r_mem_8_rden  in  1  read strobe from core.
- user_r_mem_8_data  out  DATA_W  read byte, valid the cycle after rden.
- user_r_mem_8_empty  out  1  no read data available.
- user_r_mem_8_eof  out  1  end of read stream.
- user_r_mem_8_open  in  1  host read file open.
- user_mem_8_addr  in  ADDR_W  seek address.
- user_mem_8_addr_update  in  1  load seek address.

Behaviour:
- Interface: one clock, `bus_clk`; reset `bus_rst_n` is synchronous and active-low.
- Reset values, applied on the edge where `bus_rst_n`=0:
  - ptr=0, done=0, bubble=1.
  - full=1, empty=1, eof=0, rd_data=0.
  - Memory array is not reset.
- Pointer `ptr` (ADDR_W bits) is shared by both directions.
- Priority within one cycle: reset > addr_update > wren/rden.
- addr_update=1:
  - ptr <= addr, done <= 0, bubble <= 1.
  - wren/rden in the same cycle are ignored (memory and data unchanged); this is an illegal-stimulus case and the bench flags it.
- Write, when wren=1 and full=0:
  - mem[ptr] <= data; ptr <= ptr+1 mod DEPTH (DEPTH-1 wraps to 0).
  - bubble <= 1.
  - No eof effect.
- Read, when rden=1 and empty=0:
  - rd_data <= mem[ptr] on the next edge (1-cycle latency, standard-FIFO semantics); ptr <= ptr+1 mod DEPTH.
  - If EOF_AT_END=1 and ptr==DEPTH-1: done <= 1.
  - rd_data holds its value when no read occurs.
- wren and rden together (both accepted):
  - Read-first: rd_data gets the old mem[ptr] and mem[ptr] gets the new data.
  - ptr increments by exactly 1.
  - If that location is DEPTH-1 and EOF_AT_END=1, done is set.
- bubble:
  - Set by reset, addr_update or an accepted write.
  - Cleared on the following cycle if none of these recur.
  - Guarantees read data never reflects a location mid-update.
- user_r_mem_8_empty is registered:
  - empty <= !r_open | bubble_next | done_next | rst; bubble_next/done_next are the values bubble/done take on the same edge.
  - Consequence: empty=1 during the cycle immediately after a seek or write.
  - An rden while empty=1 is ignored.
- user_r_mem_8_eof is registered:
  - eof <= done_next & r_open.
  - eof is asserted only together with empty=1.
  - Once set, eof stays high until addr_update, r_open falling, or reset.
- r_open falling edge (1->0): done <= 0. ptr is unchanged.
- user_w_mem_8_full:
  - 1 during reset and the first cycle after reset release, 0 thereafter.
  - Not affected by w_open.
  - A wren while full=1 is ignored.
- Reset mid-stream: an in-flight read's rd_data is discarded (rd_data=0), ptr=0, eof cleared; memory contents are preserved.

Test Plan:
- Reset release, no stimulus:
  - full=1 for 1 cycle then 0.
  - empty=1 while r_open=0.
  - eof=0.
- Seek and write burst:
  - addr=3 with addr_update, then 4 wrens of 0xA1,0xA2,0xA3,0xA4.
  - mem[3..6]=A1..A4 and ptr=7.
  - Seek 3 with r_open=1 and 4 rdens: data A1,A2,A3,A4, each one cycle after its rden.
- End-of-memory eof (EOF_AT_END=1):
  - Seek 30 with r_open=1 and 2 rdens: bytes mem[30], mem[31].
  - Following cycle: empty=1, eof=1.
  - Further rdens are ignored.
  - A seek to 0 clears eof and empty returns to 0 two cycles later.
- Write wrap:
  - Seek 31, write 0x55,0x66: mem[31]=0x55, mem[0]=0x66, ptr=1.
  - Repeat with EOF_AT_END=0 reading from 31: bytes 0x55,0x66 with no eof.
- Simultaneous wren+rden at ptr=10 (mem[10]=0x11, wr data 0x22):
  - rd_data=0x11, mem[10]=0x22, ptr=11.
  - empty=1 for the next cycle (bubble).
- Close and reset mid-operation:
  - Read close: after eof, r_open drops: eof=0, empty=1.
  - Reset: bus_rst_n=0 during a read burst gives rd_data=0, ptr=0, eof=0, and previously written bytes are still readable after the next seek.
